keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Sequences a 4x4 matrix keypad: drives columns one at a time (active-low), samples synchronised rows,
//  debounces press and release, and emits the raw 4-bit key index {row,col} with a 1-cycle valid strobe.
//  The output feeds key_encoding.dato_i directly; data_available_o qualifies it downstream.
// PARAMETERS
//  SCAN_TICKS      50_000  clk cycles each column is driven while idle-scanning (>=4)
//  DEBOUNCE_CYCLES 200_000 consecutive stable cycles required to accept a press or a release (>=2)
// PORTS
//  clk_i             in   1  system clock, single domain
//  rst_i             in   1  asynchronous, active-high reset
//  scan_en_i         in   1  1 = scanning runs; 0 = FSM frozen in its current state, counters hold
//  row_i             in   4  keypad rows, active-low, pulled up externally, asynchronous to clk_i
//  col_o             out  4  column drive, one-hot active-low (exactly one bit 0 at all times)
//  dato_o            out  4  raw key index {row_idx[1:0], col_idx[1:0]}, held until next accepted key
//  data_available_o  out  1  1-cycle pulse when dato_o updates with a new debounced press
//  key_held_o        out  1  1 from press acceptance until release is accepted
// BEHAVIOUR
//  Reset (async, while rst_i=1): col_o=4'b1110, dato_o=4'b0000, data_available_o=0, key_held_o=0,
//   state=SCAN, column index=0, all counters=0. Reset mid-press discards the press, no strobe.
//  row_i passes a 2-flop synchroniser (rows_s); all decisions use rows_s only. Sync latency 2 cycles.
//  Index map: col_o[k]=0 drives column k; rows_s[j]=0 means row j active; dato_o={j[1:0],k[1:0]}.
//  Multiple active rows in one column: lowest j wins. Multiple keys across columns: first column hit wins.
//  FSM states:
//   SCAN: tick counter counts 0..SCAN_TICKS-1. On last tick: if rows_s!=4'hF -> capture j into cand_row,
//    go DEBOUNCE (column held, stable counter=0); else rotate column k->(k+1) mod 4 (3 wraps to 0), tick=0.
//   DEBOUNCE: each cycle, if rows_s pattern still has cand_row as lowest active row -> stable counter++,
//    else -> back to SCAN, rotate to next column (bounce rejected, no strobe).
//    When counter reaches DEBOUNCE_CYCLES-1 -> VALID.
//   VALID (1 cycle): dato_o<={cand_row,k}, data_available_o=1, key_held_o<=1 -> WAIT_RELEASE.
//   WAIT_RELEASE: column held. rows_s==4'hF for DEBOUNCE_CYCLES consecutive cycles -> key_held_o<=0,
//    rotate column, tick=0, go SCAN. Any active row resets the release counter (no repeat strobe).
//  data_available_o is registered, high exactly one cycle per accepted press; never two in a row.
//  Press latency: <= 4*SCAN_TICKS + DEBOUNCE_CYCLES + 4 cycles from stable row_i edge to strobe.
//  scan_en_i=0: all registers hold (col_o static, no strobe); resuming continues where frozen.
//  Counters sized $clog2(max(SCAN_TICKS,DEBOUNCE_CYCLES)); no overflow (saturating compare stops them).
//  Unreachable state encodings -> SCAN with outputs at reset values (default branch).
// STRUCTURE
//  keypad_pkg: typedef enum logic [1:0] {SCAN, DEBOUNCE, VALID, WAIT_RELEASE} kbd_state_t;
//   localparam ROWS_IDLE = 4'hF; raw-index constants KEY_RAW_1=4'hF ... KEY_RAW_D=4'h0 (bench use).
//  Sub-module: keypad_row_sync (4-bit 2-flop synchroniser, async reset to 4'hF).
//  FSM, tick counter, stable counter, column register and output registers live in keypad_scanner.
//  key_encoding is instantiated by the parent, not inside this block.
// TESTING  (SCAN_TICKS=8, DEBOUNCE_CYCLES=16, bench models keypad: row j low when its key column driven)
//  1 Idle rows=4'hF, 40 cycles -> col_o cycles 1110,1101,1011,0111,1110 every 8 cycles; no strobe.
//  2 Hold key row3/col3 ("1") clean -> one strobe, dato_o=4'hF, key_held_o=1; release -> key_held_o=0
//     16+ cycles after release, scanning resumes at column 0.
//  3 Key row0/col1 ("#") bouncing 5 cycles then stable -> exactly one strobe, dato_o=4'h1.
//  4 Glitch row2 low for 6 cycles only in column 2 -> no strobe, column advances to 3.
//  5 Rows 1 and 2 both low in column 0 -> dato_o=4'h4 ("C"); bounce on release -> no second strobe.
//  6 Assert rst_i mid-DEBOUNCE and mid-WAIT_RELEASE -> outputs at reset values immediately
//     (async), no strobe after release of rst_i until a fresh debounced press.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Also holds the raw key indices that the key_encoding stage decodes.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned KEY_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    VALID        = 2'd2,
    WAIT_RELEASE = 2'd3
  } kbd_state_t;

  localparam logic [ROW_W-1:0] ROWS_IDLE = 4'hF;
  localparam logic [COL_W-1:0] COL_RESET = 4'b1110;

  // Raw {row,col} index of each legend; row 3 / column 3 is the "1" corner.
  localparam logic [KEY_W-1:0] KEY_RAW_1    = 4'hF;
  localparam logic [KEY_W-1:0] KEY_RAW_2    = 4'hE;
  localparam logic [KEY_W-1:0] KEY_RAW_3    = 4'hD;
  localparam logic [KEY_W-1:0] KEY_RAW_A    = 4'hC;
  localparam logic [KEY_W-1:0] KEY_RAW_4    = 4'hB;
  localparam logic [KEY_W-1:0] KEY_RAW_5    = 4'hA;
  localparam logic [KEY_W-1:0] KEY_RAW_6    = 4'h9;
  localparam logic [KEY_W-1:0] KEY_RAW_B    = 4'h8;
  localparam logic [KEY_W-1:0] KEY_RAW_7    = 4'h7;
  localparam logic [KEY_W-1:0] KEY_RAW_8    = 4'h6;
  localparam logic [KEY_W-1:0] KEY_RAW_9    = 4'h5;
  localparam logic [KEY_W-1:0] KEY_RAW_C    = 4'h4;
  localparam logic [KEY_W-1:0] KEY_RAW_STAR = 4'h3;
  localparam logic [KEY_W-1:0] KEY_RAW_0    = 4'h2;
  localparam logic [KEY_W-1:0] KEY_RAW_HASH = 4'h1;
  localparam logic [KEY_W-1:0] KEY_RAW_D    = 4'h0;

  // Index of the lowest active (low) row; only meaningful when some row is active.
  function automatic logic [IDX_W-1:0] lowest_row(input logic [ROW_W-1:0] rows);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int j = ROW_W - 1; j >= 0; j--) begin
      if (!rows[j]) idx = IDX_W'(j);
    end
    return idx;
  endfunction

  // One-hot active-low drive pattern for a column index.
  function automatic logic [COL_W-1:0] col_drive(input logic [IDX_W-1:0] idx);
    return ~(COL_W'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser bringing the asynchronous keypad rows into the clk domain.
// Resets to the idle (all rows high) pattern so no phantom key is seen.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] rows_async,
  output logic [ROW_W-1:0] rows_sync
);

  logic [ROW_W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta      <= ROWS_IDLE;
      rows_sync <= ROWS_IDLE;
    end else begin
      meta      <= rows_async;
      rows_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces press and release
// on synchronised rows, and strobes the raw {row,col} index of each accepted key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 50_000,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_en_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [COL_W-1:0] col_o,
  output logic [KEY_W-1:0] dato_o,
  output logic             data_available_o,
  output logic             key_held_o
);

  localparam int unsigned MAX_CNT = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ROW_W-1:0] rows_s;

  kbd_state_t       state,    state_nx;
  logic [CNT_W-1:0] tick_cnt, tick_nx;
  logic [CNT_W-1:0] stab_cnt, stab_nx;
  logic [IDX_W-1:0] col_idx,  col_idx_nx;
  logic [IDX_W-1:0] cand_row, cand_nx;
  logic [COL_W-1:0] col_nx;
  logic [KEY_W-1:0] dato_nx;
  logic             dav_nx;
  logic             held_nx;
  logic             row_hit;
  logic [IDX_W-1:0] hit_row;

  keypad_row_sync u_row_sync (
    .clk        (clk_i),
    .rst        (rst_i),
    .rows_async (row_i),
    .rows_sync  (rows_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= SCAN;
      tick_cnt         <= '0;
      stab_cnt         <= '0;
      col_idx          <= '0;
      cand_row         <= '0;
      col_o            <= COL_RESET;
      dato_o           <= '0;
      data_available_o <= 1'b0;
      key_held_o       <= 1'b0;
    end else begin
      state            <= state_nx;
      tick_cnt         <= tick_nx;
      stab_cnt         <= stab_nx;
      col_idx          <= col_idx_nx;
      cand_row         <= cand_nx;
      col_o            <= col_nx;
      dato_o           <= dato_nx;
      data_available_o <= dav_nx;
      key_held_o       <= held_nx;
    end
  end

  // Next-state and output decisions; a low scan_en_i leaves every register unchanged.
  always_comb begin
    state_nx   = state;
    tick_nx    = tick_cnt;
    stab_nx    = stab_cnt;
    col_idx_nx = col_idx;
    cand_nx    = cand_row;
    dato_nx    = dato_o;
    dav_nx     = 1'b0;
    held_nx    = key_held_o;
    row_hit    = (rows_s != ROWS_IDLE);
    hit_row    = lowest_row(rows_s);

    if (scan_en_i) begin
      case (state)
        SCAN: begin
          if (tick_cnt >= SCAN_LAST) begin
            tick_nx = '0;
            if (row_hit) begin
              cand_nx  = hit_row;
              stab_nx  = '0;
              state_nx = DEBOUNCE;
            end else begin
              col_idx_nx = col_idx + IDX_W'(1);
            end
          end else begin
            tick_nx = tick_cnt + CNT_W'(1);
          end
        end

        DEBOUNCE: begin
          if (row_hit && (hit_row == cand_row)) begin
            if (stab_cnt >= DEB_LAST) begin
              state_nx = VALID;
            end else begin
              stab_nx = stab_cnt + CNT_W'(1);
            end
          end else begin
            // Bounce rejected: move on rather than re-testing the same column.
            state_nx   = SCAN;
            tick_nx    = '0;
            stab_nx    = '0;
            col_idx_nx = col_idx + IDX_W'(1);
          end
        end

        VALID: begin
          dato_nx  = {cand_row, col_idx};
          dav_nx   = 1'b1;
          held_nx  = 1'b1;
          stab_nx  = '0;
          state_nx = WAIT_RELEASE;
        end

        WAIT_RELEASE: begin
          if (row_hit) begin
            stab_nx = '0;
          end else if (stab_cnt >= DEB_LAST) begin
            held_nx    = 1'b0;
            state_nx   = SCAN;
            tick_nx    = '0;
            stab_nx    = '0;
            col_idx_nx = col_idx + IDX_W'(1);
          end else begin
            stab_nx = stab_cnt + CNT_W'(1);
          end
        end

        default: begin
          state_nx   = SCAN;
          tick_nx    = '0;
          stab_nx    = '0;
          col_idx_nx = '0;
          cand_nx    = '0;
          dato_nx    = '0;
          held_nx    = 1'b0;
        end
      endcase
    end

    col_nx = col_drive(col_idx_nx);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised scoreboard bench for keypad_scanner with a behavioural keypad matrix model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int unsigned ST = 8;
  localparam int unsigned DB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] dato;
  logic       dav;
  logic       held;

  logic [15:0] pressed;   // bit j*4+k set: key at row j, column k is closed
  logic        glitch2;   // spurious row-2 contact seen only while column 2 is driven

  int checks = 0;
  int fails  = 0;
  int strobes = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CYCLES(DB)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .scan_en_i        (scan_en),
    .row_i            (row_i),
    .col_o            (col_o),
    .dato_o           (dato),
    .data_available_o (dav),
    .key_held_o       (held)
  );

  // A closed key pulls its row low whenever its column is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        if (pressed[j*4+k] && !col_o[k]) row_i[j] = 1'b0;
    if (glitch2 && !col_o[2]) row_i[2] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected key: lowest closed row in the (single) column that holds closed keys.
  function automatic logic [3:0] expected_key(input logic [15:0] keys);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        if (keys[j*4+k]) return {2'(j), 2'(k)};
    return 4'h0;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    logic prev_dav;
    logic [3:0] e;
    prev_dav = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && dav) begin
        strobes++;
        check("dav_single_cycle", 4'(prev_dav), 4'h0);
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got dato %h expected no strobe at %0t", dato, $time);
        end else begin
          e = exp_q.pop_front();
          check("dato", dato, e);
          check("held_at_strobe", 4'(held), 4'h1);
        end
      end
      prev_dav = dav && !rst;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b1;
    pressed = '0;
    glitch2 = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int n0, input int budget);
    for (int c = 0; c < budget && strobes == n0; c++) @(negedge clk);
    check("strobe_count", 4'(strobes - n0), 4'h1);
  endtask

  task automatic wait_release(input int budget);
    for (int c = 0; c < budget && held; c++) @(negedge clk);
    check("held_released", 4'(held), 4'h0);
  endtask

  task automatic do_press(input logic [15:0] keys, input int b_in, input int hold, input int b_out);
    int n0;
    n0 = strobes;
    exp_q.push_back(expected_key(keys));
    for (int i = 0; i < b_in; i++) begin
      pressed = (i % 2 == 0) ? keys : 16'h0;
      @(negedge clk);
    end
    pressed = keys;
    wait_strobe(n0, 150);
    repeat (hold) @(negedge clk);
    check("held_during", 4'(held), 4'h1);
    for (int i = 0; i < b_out; i++) begin
      pressed = (i % 2 == 0) ? 16'h0 : keys;
      @(negedge clk);
    end
    pressed = '0;
    wait_release(80);
    check("queue_drained", 4'(exp_q.size()), 4'h0);
  endtask

  initial begin
    int en;
    int n0;
    logic [3:0] exp_col;
    logic [15:0] keys;
    int j, k, j2;

    scan_en = 1'b1;
    pressed = '0;
    glitch2 = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_col", col_o, 4'b1110);
    check("rst_dato", dato, 4'h0);
    check("rst_dav", 4'(dav), 4'h0);
    check("rst_held", 4'(held), 4'h0);
    reset_dut();

    // Idle rotation, with a freeze window in the middle.
    en = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      if (scan_en) en++;
      #1;
      exp_col = ~(4'b0001 << ((en / ST) % 4));
      check("idle_col", col_o, exp_col);
      scan_en = !(c >= 40 && c < 55);
    end
    scan_en = 1'b1;
    check("idle_held", 4'(held), 4'h0);

    // Clean press of "1", release returns scan to column 0.
    reset_dut();
    do_press(16'h8000, 0, 10, 0);
    check("dato_kept_1", dato, KEY_RAW_1);
    check("resume_col0", col_o, 4'b1110);

    // "#" with contact bounce.
    do_press(16'h0002, 5, 10, 0);
    check("dato_kept_hash", dato, KEY_RAW_HASH);

    // Short glitch on row 2 in column 2 is rejected.
    n0 = strobes;
    for (int c = 0; c < 64 && col_o !== 4'b1011; c++) @(negedge clk);
    check("reach_col2", col_o, 4'b1011);
    repeat (3) @(negedge clk);
    glitch2 = 1'b1;
    repeat (6) @(negedge clk);
    glitch2 = 1'b0;
    for (int c = 0; c < 64 && col_o === 4'b1011; c++) @(negedge clk);
    check("glitch_next_col", col_o, 4'b0111);
    check("glitch_no_strobe", 4'(strobes - n0), 4'h0);

    // Rows 1 and 2 in column 0: lowest row wins; release bounce yields no repeat.
    do_press(16'h0110, 0, 8, 5);
    check("dato_kept_c", dato, KEY_RAW_C);

    // Reset while debouncing.
    reset_dut();
    pressed = 16'h0100;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstdb_col", col_o, 4'b1110);
    check("rstdb_dato", dato, 4'h0);
    check("rstdb_held", 4'(held), 4'h0);
    pressed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = strobes;
    repeat (60) @(negedge clk);
    check("rstdb_no_strobe", 4'(strobes - n0), 4'h0);

    // Reset while waiting for release.
    n0 = strobes;
    exp_q.push_back(KEY_RAW_1);
    pressed = 16'h8000;
    wait_strobe(n0, 150);
    repeat (3) @(negedge clk);
    check("rstwr_held_before", 4'(held), 4'h1);
    #2 rst = 1'b1;
    #1;
    check("rstwr_col", col_o, 4'b1110);
    check("rstwr_dato", dato, 4'h0);
    check("rstwr_held", 4'(held), 4'h0);
    pressed = '0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = strobes;
    repeat (60) @(negedge clk);
    check("rstwr_no_strobe", 4'(strobes - n0), 4'h0);
    do_press(16'h0020, 2, 5, 0);

    // Randomised presses: any key, sometimes two rows in one column.
    for (int t = 0; t < 12; t++) begin
      k = int'($urandom_range(0, 3));
      j = int'($urandom_range(0, 3));
      keys = '0;
      keys[j*4+k] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        j2 = int'($urandom_range(0, 3));
        keys[j2*4+k] = 1'b1;
      end
      do_press(keys, int'($urandom_range(0, 5)), int'($urandom_range(2, 30)),
               int'($urandom_range(0, 5)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
